// File: rtl/framebuffer_arbiter.sv
`timescale 1ns/1ps
// Shares the single framebuffer RAM port between display reads (always first), a buffered
// pixel writer and a background full-screen clear that only uses cycles the display leaves idle.
module framebuffer_arbiter #(
  parameter int AW          = 16,
  parameter int DW          = 15,
  parameter int FIFO_DEPTH  = 16,
  parameter int RAM_LATENCY = 1,
  parameter logic [DW-1:0] CLEAR_COLOR = '0
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        disp_req,
  input  logic [AW-1:0]               disp_addr,
  output logic [DW-1:0]               disp_pixel,
  output logic                        disp_pixel_valid,
  input  logic                        wr_valid,
  output logic                        wr_ready,
  input  logic [AW-1:0]               wr_addr,
  input  logic [DW-1:0]               wr_data,
  input  logic                        clear_start,
  output logic                        clear_busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic [AW-1:0]               ram_address,
  output logic [DW-1:0]               ram_data,
  output logic                        ram_wren,
  input  logic [DW-1:0]               ram_q
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t state, next_state;

  logic [AW-1:0]        clear_cnt;
  logic [PW-1:0]        rd_ptr, wr_ptr;
  logic [LW-1:0]        level;
  logic [RAM_LATENCY-1:0] valid_sr;

  logic [AW-1:0] fifo_addr [FIFO_DEPTH];
  logic [DW-1:0] fifo_data [FIFO_DEPTH];

  logic push, pop, clear_step, start_clear;

  assign start_clear = (state == IDLE) && clear_start;
  assign wr_ready    = (level < LW'(FIFO_DEPTH)) && (state == IDLE) && !reset;
  assign push        = wr_valid && wr_ready;
  assign clear_busy  = (state == CLEAR) && !reset;
  assign fifo_level  = reset ? '0 : level;

  assign disp_pixel_valid = valid_sr[RAM_LATENCY-1] && !reset;
  assign disp_pixel       = disp_pixel_valid ? ram_q : '0;

  // Port mux: display read, then clear, then FIFO pop. A starting clear discards the FIFO,
  // so its head is not written on that cycle either.
  always_comb begin
    ram_address = disp_addr;
    ram_data    = '0;
    ram_wren    = 1'b0;
    pop         = 1'b0;
    clear_step  = 1'b0;
    if (!reset && !disp_req) begin
      if (state == CLEAR) begin
        ram_address = clear_cnt;
        ram_data    = CLEAR_COLOR;
        ram_wren    = 1'b1;
        clear_step  = 1'b1;
      end else if (level != '0 && !clear_start) begin
        ram_address = fifo_addr[rd_ptr];
        ram_data    = fifo_data[rd_ptr];
        ram_wren    = 1'b1;
        pop         = 1'b1;
      end
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (clear_start) next_state = CLEAR;
      CLEAR: if (clear_step && (&clear_cnt)) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      clear_cnt <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      level     <= '0;
      valid_sr  <= '0;
    end else begin
      state       <= next_state;
      valid_sr[0] <= disp_req;
      for (int i = 1; i < RAM_LATENCY; i++) valid_sr[i] <= valid_sr[i-1];
      if (start_clear) begin
        clear_cnt <= '0;
        rd_ptr    <= '0;
        wr_ptr    <= '0;
        level     <= '0;
      end else begin
        if (clear_step) clear_cnt <= clear_cnt + AW'(1);
        if (push)       wr_ptr    <= wr_ptr + PW'(1);
        if (pop)        rd_ptr    <= rd_ptr + PW'(1);
        level <= level + LW'(push) - LW'(pop);
      end
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers and level above.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_addr[wr_ptr] <= wr_addr;
      fifo_data[wr_ptr] <= wr_data;
    end
  end

endmodule

// File: tb/tb_framebuffer_arbiter.sv
`timescale 1ns/1ps
// Randomised and directed bench for framebuffer_arbiter against a queue-based model of the
// RAM contents, the write FIFO and the clear sweep.
module tb_framebuffer_arbiter;

  localparam int AW = 16;
  localparam int DW = 15;
  localparam int DEPTH = 16;
  localparam int WORDS = 65536;
  localparam logic [DW-1:0] CLEAR = 15'h0000;

  logic clock = 1'b0;
  logic reset, disp_req, wr_valid, clear_start;
  logic [AW-1:0] disp_addr, wr_addr, ram_address;
  logic [DW-1:0] wr_data, disp_pixel, ram_data, ram_q;
  logic disp_pixel_valid, wr_ready, clear_busy, ram_wren;
  logic [4:0] fifo_level;

  logic poke_en;
  logic [AW-1:0] poke_addr;
  logic [DW-1:0] poke_data;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  framebuffer_arbiter #(.AW(AW), .DW(DW), .FIFO_DEPTH(DEPTH), .RAM_LATENCY(1),
                        .CLEAR_COLOR(CLEAR)) dut (
    .clock(clock), .reset(reset),
    .disp_req(disp_req), .disp_addr(disp_addr),
    .disp_pixel(disp_pixel), .disp_pixel_valid(disp_pixel_valid),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .clear_start(clear_start), .clear_busy(clear_busy), .fifo_level(fifo_level),
    .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren), .ram_q(ram_q)
  );

  function automatic logic [DW-1:0] initVal(input int a);
    int t;
    t = a * 37 + 5;
    return t[DW-1:0];
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic req, input logic [AW-1:0] da, input logic wv,
                               input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                               input logic cs);
    @(posedge clock);
    #1;
    disp_req = req; disp_addr = da; wr_valid = wv; wr_addr = wa; wr_data = wd;
    clear_start = cs;
  endtask

  // Behavioural single-port RAM with one cycle of read latency
  logic [DW-1:0] ram_mem [WORDS];
  initial begin
    for (int i = 0; i < WORDS; i++) ram_mem[i] = initVal(i);
    forever begin
      @(posedge clock);
      ram_q <= ram_mem[ram_address];
      if (ram_wren) ram_mem[ram_address] = ram_data;
      if (poke_en)  ram_mem[poke_addr] = poke_data;
    end
  end

  // Reference model: expected RAM image, pending writes, clear progress
  typedef struct packed {logic [AW-1:0] a; logic [DW-1:0] d;} wr_t;
  wr_t fq[$];
  logic [DW-1:0] shadow [WORDS];
  logic clearing, pend_valid, exp_ready, exp_wren, was_clearing;
  logic [DW-1:0] pend_pix, exp_data;
  logic [AW-1:0] exp_addr;
  int clr_idx, clr_writes;

  initial begin
    clearing = 1'b0; pend_valid = 1'b0; pend_pix = '0; clr_idx = 0; clr_writes = 0;
    for (int i = 0; i < WORDS; i++) shadow[i] = initVal(i);
    forever begin
      @(negedge clock);
      if (reset) begin
        checkOutput("rst_wren", 32'(ram_wren), 0);
        checkOutput("rst_wr_ready", 32'(wr_ready), 0);
        checkOutput("rst_busy", 32'(clear_busy), 0);
        checkOutput("rst_valid", 32'(disp_pixel_valid), 0);
        checkOutput("rst_level", 32'(fifo_level), 0);
        fq.delete();
        clearing = 1'b0; clr_idx = 0; pend_valid = 1'b0;
      end else begin
        exp_ready = !clearing && (fq.size() < DEPTH);
        exp_wren = 1'b0; exp_addr = disp_addr; exp_data = '0;
        if (!disp_req) begin
          if (clearing) begin
            exp_wren = 1'b1; exp_addr = AW'(clr_idx); exp_data = CLEAR;
          end else if (fq.size() > 0 && !clear_start) begin
            exp_wren = 1'b1; exp_addr = fq[0].a; exp_data = fq[0].d;
          end
        end
        checkOutput("wr_ready", 32'(wr_ready), 32'(exp_ready));
        checkOutput("clear_busy", 32'(clear_busy), 32'(clearing));
        checkOutput("fifo_level", 32'(fifo_level), fq.size());
        checkOutput("disp_valid", 32'(disp_pixel_valid), 32'(pend_valid));
        checkOutput("disp_pixel", 32'(disp_pixel), pend_valid ? 32'(pend_pix) : 0);
        checkOutput("ram_wren", 32'(ram_wren), 32'(exp_wren));
        checkOutput("ram_address", 32'(ram_address), 32'(exp_addr));
        if (exp_wren) checkOutput("ram_data", 32'(ram_data), 32'(exp_data));
        if (ram_wren && clear_busy) clr_writes++;

        was_clearing = clearing;
        pend_valid = disp_req;
        if (disp_req) pend_pix = shadow[disp_addr];
        if (exp_wren) shadow[exp_addr] = exp_data;
        if (exp_wren && clearing) begin
          clr_idx++;
          if (clr_idx == WORDS) begin clearing = 1'b0; clr_idx = 0; end
        end else if (exp_wren) begin
          void'(fq.pop_front());
        end
        if (wr_valid && exp_ready) fq.push_back({wr_addr, wr_data});
        if (!was_clearing && clear_start) begin
          fq.delete(); clearing = 1'b1; clr_idx = 0;
        end
      end
      if (poke_en) shadow[poke_addr] = poke_data;
    end
  end

  initial begin
    #1_500_000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int start_writes, bad, cyc;
    reset = 1'b1; disp_req = 1'b0; disp_addr = '0; wr_valid = 1'b0; wr_addr = '0;
    wr_data = '0; clear_start = 1'b0; poke_en = 1'b0; poke_addr = '0; poke_data = '0;

    // Reset for three cycles, then idle ready state
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    checkOutput("t1_wr_ready", 32'(wr_ready), 1);
    checkOutput("t1_busy", 32'(clear_busy), 0);
    checkOutput("t1_level", 32'(fifo_level), 0);
    checkOutput("t1_wren", 32'(ram_wren), 0);

    // Preloaded pixel appears one cycle after the display request
    @(posedge clock); #1;
    poke_en = 1'b1; poke_addr = 16'h1234; poke_data = 15'h7C00;
    applyStimulus(1'b1, 16'h1234, 1'b0, '0, '0, 1'b0);
    poke_en = 1'b0;
    applyStimulus(1'b0, 16'h0000, 1'b0, '0, '0, 1'b0);
    @(negedge clock);
    checkOutput("t2_valid", 32'(disp_pixel_valid), 1);
    checkOutput("t2_pixel", 32'(disp_pixel), 32'h7C00);
    checkOutput("t2_wren", 32'(ram_wren), 0);

    // Fill the FIFO behind a busy display, then drain it in order
    for (int i = 0; i < 16; i++)
      applyStimulus(1'b1, AW'(i), 1'b1, AW'(i), DW'(16'h100 + i), 1'b0);
    applyStimulus(1'b1, 16'h0040, 1'b0, '0, '0, 1'b0);
    @(negedge clock);
    checkOutput("t3_full_ready", 32'(wr_ready), 0);
    checkOutput("t3_full_level", 32'(fifo_level), 16);
    for (int k = 0; k < 16; k++) begin
      applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0);
      @(negedge clock);
      checkOutput("t3_pop_wren", 32'(ram_wren), 1);
      checkOutput("t3_pop_addr", 32'(ram_address), k);
      checkOutput("t3_pop_data", 32'(ram_data), 32'h100 + k);
      if (k < 2) checkOutput("t3_ready_after_pop", 32'(wr_ready), k);
    end

    // Random traffic over a small address window so reads hit freshly written pixels
    for (int n = 0; n < 3000; n++) begin
      applyStimulus(($urandom_range(99) < (n < 1500 ? 70 : 30)), AW'($urandom_range(31)),
                    ($urandom_range(99) < 60), AW'($urandom_range(31)), DW'($urandom), 1'b0);
    end
    repeat (20) applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0);

    // Clear discards queued writes, then a reset aborts the sweep at address 1000
    for (int i = 0; i < 5; i++)
      applyStimulus(1'b1, 16'h0100, 1'b1, AW'(16'hF000 + i), 15'h5555, 1'b0);
    applyStimulus(1'b1, 16'h0100, 1'b0, '0, '0, 1'b1);
    applyStimulus(1'b1, 16'h0100, 1'b0, '0, '0, 1'b0);
    @(negedge clock);
    checkOutput("t5_level", 32'(fifo_level), 0);
    checkOutput("t5_busy", 32'(clear_busy), 1);
    applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0);
    cyc = 0;
    while (clr_idx != 1000 && cyc < 2000) begin
      @(posedge clock); #1;
      cyc++;
    end
    checkOutput("t6_reach_1000", clr_idx, 1000);
    reset = 1'b1;
    @(negedge clock);
    checkOutput("t6_wren_abort", 32'(ram_wren), 0);
    @(posedge clock); #1;
    @(negedge clock);
    checkOutput("t6_busy_reset", 32'(clear_busy), 0);
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    checkOutput("t6_busy_after", 32'(clear_busy), 0);
    checkOutput("t6_ready_after", 32'(wr_ready), 1);
    checkOutput("t6_ram_999", 32'(ram_mem[999]), 32'(CLEAR));
    checkOutput("t6_ram_1000", 32'(ram_mem[1000]), 32'(initVal(1000)));
    for (int i = 0; i < 5; i++)
      checkOutput("t5_not_written", 32'(ram_mem[16'hF000 + i]), 32'(initVal(16'hF000 + i)));

    // Full clear with an intermittent display and blocked writer; restart pulse ignored
    start_writes = clr_writes;
    applyStimulus(1'b1, 16'h1234, 1'b0, '0, '0, 1'b1);
    cyc = 0;
    do begin
      applyStimulus((cyc % 16) == 0, AW'($urandom), $urandom_range(1), AW'($urandom),
                    DW'($urandom), cyc == 30000);
      cyc++;
      @(negedge clock);
    end while ((clear_busy || cyc < 2) && cyc < 80000);
    checkOutput("t4_finished", 32'(clear_busy), 0);
    checkOutput("t4_write_count", clr_writes - start_writes, WORDS);
    applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0);
    bad = 0;
    for (int i = 0; i < WORDS; i++) if (ram_mem[i] != CLEAR) bad++;
    checkOutput("t4_all_cleared", bad, 0);
    repeat (3) applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
